// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control sequencer: steps fetch/decode/execute/mem/writeback,
// decodes opcode/funct, resolves BEQ on zero and traps on illegal ops or overflow.
module mips_multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        ovf,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_we,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_ctl,
   output logic        trap,
   output logic [3:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,  S_JEX    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
      S_TRAP   = 4'd12
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2,
                          ALU_SLT = 3'd3, ALU_AND = 3'd4, ALU_NOR = 3'd6,
                          ALU_OR  = 3'd7;

   state_e      state_q, state_d;
   logic        trap_q, trap_d;
   logic [31:0] retired_q, retired_d;

   logic [2:0]  rt_alu;
   logic        funct_ok;
   logic        funct_arith;

   always_comb begin
      rt_alu   = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         6'h20:   rt_alu = ALU_ADD;
         6'h22:   rt_alu = ALU_SUB;
         6'h24:   rt_alu = ALU_AND;
         6'h25:   rt_alu = ALU_OR;
         6'h26:   rt_alu = ALU_XOR;
         6'h27:   rt_alu = ALU_NOR;
         6'h2A:   rt_alu = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   // Only signed add/sub can trap; logic ops and SLT ignore the ALU ovf flag.
   assign funct_arith = (funct == 6'h20) || (funct == 6'h22);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               6'h00:         state_d = funct_ok ? S_RTEXEC : S_TRAP;
               6'h23, 6'h2B:  state_d = S_MEMADR;
               6'h04:         state_d = S_BEQEX;
               6'h02:         state_d = S_JEX;
               6'h08:         state_d = S_ADDIEX;
               default:       state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (opcode == 6'h23) ? S_MEMRD :
                             (opcode == 6'h2B) ? S_MEMWR : S_TRAP;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RTEXEC: state_d = (ovf && funct_arith) ? S_TRAP : S_RTWB;
         S_RTWB:   state_d = S_FETCH;
         S_BEQEX:  state_d = S_FETCH;
         S_JEX:    state_d = S_FETCH;
         S_ADDIEX: state_d = ovf ? S_TRAP : S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase
   end

   // Any entry into FETCH from another state is an instruction completing.
   assign trap_d    = trap_q | (state_d == S_TRAP);
   assign retired_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ?
                      retired_q + 32'd1 : retired_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         trap_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         trap_q    <= trap_d;
         retired_q <= retired_d;
      end
   end

   logic mem_req_s, mem_we_s, ir_we_s, pc_we_s, reg_we_s;

   always_comb begin
      mem_req_s  = 1'b0;
      mem_we_s   = 1'b0;
      iord       = 1'b0;
      ir_we_s    = 1'b0;
      pc_we_s    = 1'b0;
      pc_src     = 2'b00;
      reg_we_s   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctl    = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            alu_src_b = 2'b01;
            ir_we_s   = mem_ready;
            pc_we_s   = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord      = 1'b1;
         end
         S_MEMWB: begin
            reg_we_s   = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            iord      = 1'b1;
         end
         S_RTEXEC: begin
            alu_src_a = 1'b1;
            alu_ctl   = rt_alu;
         end
         S_RTWB: begin
            reg_we_s = 1'b1;
            reg_dst  = 1'b1;
            alu_ctl  = rt_alu;
         end
         S_BEQEX: begin
            alu_src_a = 1'b1;
            alu_ctl   = ALU_SUB;
            pc_src    = 2'b01;
            pc_we_s   = zero;
         end
         S_JEX: begin
            pc_src  = 2'b10;
            pc_we_s = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: reg_we_s = 1'b1;
         default: ;
      endcase
   end

   // Reset gates strobes combinationally so an in-flight access dies immediately.
   assign mem_req = mem_req_s & rst_n;
   assign mem_we  = mem_we_s  & rst_n;
   assign ir_we   = ir_we_s   & rst_n;
   assign pc_we   = pc_we_s   & rst_n;
   assign reg_we  = reg_we_s  & rst_n;
   assign trap    = trap_q;
   assign state   = state_q;
   assign retired = retired_q;

endmodule
